// File: rtl/sa_pkg.sv
// Shared types and helpers for the systolic-array drain path.
package sa_pkg;

   localparam int ACC_W_DEF = 20;

   typedef enum logic [1:0] {IDLE, CAPTURE, STREAM} state_t;

   // ceil(log2(v)), for sizing index and counter fields
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/sa_deskew_capture.sv
// Deskew capture: counts cycles from drain start and samples each column's
// skewed word stream into the N x N tile buffer. Column c lags column 0 by c
// cycles, and within a column the bottom PE's result arrives first.
module sa_deskew_capture
   import sa_pkg::*;
#(
   parameter  int N         = 4,
   parameter  int ACC_W     = ACC_W_DEF,
   parameter  int FIRST_LAT = 2,
   localparam int LG        = clog2(N),
   localparam int CW        = clog2(FIRST_LAT + 2 * N) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 sync_reset,
   input  logic                 start,
   input  logic                 en,
   input  logic [N*ACC_W-1:0]   col_in,
   input  logic [2*LG-1:0]      rd_idx,
   output logic [ACC_W-1:0]     rd_data,
   output logic                 cap_done
);

   localparam logic [CW-1:0] LAST = CW'(FIRST_LAT + 2 * N - 3);

   logic [CW-1:0]                         cap_cnt;
   logic [N-1:0][N-1:0][ACC_W-1:0]        mem;

   // skew counter: cleared on drain start, runs while capturing
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                     cap_cnt <= '0;
      else if (sync_reset || start) cap_cnt <= '0;
      else if (en)                  cap_cnt <= cap_cnt + CW'(1);
   end

   assign cap_done = en && (cap_cnt == LAST);

   // word k of column c lands on its diagonal slot; several columns may write at once
   always_ff @(posedge clk) begin
      if (en) begin
         for (int c = 0; c < N; c++) begin
            for (int k = 0; k < N; k++) begin
               if (cap_cnt == CW'(FIRST_LAT - 1 + c + k))
                  mem[N-1-k][c] <= col_in[c*ACC_W +: ACC_W];
            end
         end
      end
   end

   assign rd_data = mem[rd_idx[2*LG-1:LG]][rd_idx[LG-1:0]];

endmodule

// File: rtl/sa_drain_collector.sv
// Drain collector: captures the skewed partial sums leaving the bottom of the
// systolic array, then streams the tile row-major over valid/ready.
// Build option: define DRAIN_RELU_EN to clamp negative words to zero on output.
module sa_drain_collector
   import sa_pkg::*;
#(
   parameter  int N         = 4,
   parameter  int ACC_W     = ACC_W_DEF,
   parameter  int FIRST_LAT = 2,
   localparam int LG        = clog2(N),
   localparam int IW        = 2 * LG
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 sync_reset,
   input  logic                 drain_start,
   input  logic [N*ACC_W-1:0]   col_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_W-1:0]     out_data,
   output logic [LG-1:0]        out_row,
   output logic [LG-1:0]        out_col,
   output logic                 out_last,
   output logic                 busy,
   output logic                 overrun
);

   localparam logic [IW-1:0] LAST_IDX = IW'(N * N - 1);

   state_t           state;
   logic [IW-1:0]    idx;      // next tile word to load into the output register
   logic [ACC_W-1:0] rd_data;
   logic             cap_done;

   sa_deskew_capture #(.N(N), .ACC_W(ACC_W), .FIRST_LAT(FIRST_LAT)) u_cap (
      .clk        (clk),
      .rst        (rst),
      .sync_reset (sync_reset),
      .start      ((state == IDLE) && drain_start),
      .en         (state == CAPTURE),
      .col_in     (col_in),
      .rd_idx     (idx),
      .rd_data    (rd_data),
      .cap_done   (cap_done)
   );

   function automatic logic [ACC_W-1:0] shape(input logic [ACC_W-1:0] w);
`ifdef DRAIN_RELU_EN
      return w[ACC_W-1] ? '0 : w;
`else
      return w;
`endif
   endfunction

   assign busy = (state != IDLE);

   // stream FSM with registered outputs; the output register is refilled on
   // every accepted word, giving one word per cycle under constant ready
   always_ff @(posedge clk or negedge rst) begin
      if (!rst || sync_reset) begin
         state     <= IDLE;
         idx       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_row   <= '0;
         out_col   <= '0;
         out_last  <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         overrun <= drain_start && (state != IDLE);
         case (state)
            IDLE: begin
               if (drain_start) state <= CAPTURE;
            end
            CAPTURE: begin
               // word 0 was written well before the final column word
               if (cap_done) begin
                  state     <= STREAM;
                  out_valid <= 1'b1;
                  out_data  <= shape(rd_data);
                  out_row   <= idx[IW-1:LG];
                  out_col   <= idx[LG-1:0];
                  out_last  <= (idx == LAST_IDX);
                  idx       <= idx + IW'(1);
               end
            end
            STREAM: begin
               if (out_ready) begin
                  if (out_last) begin
                     state     <= IDLE;
                     idx       <= '0;
                     out_valid <= 1'b0;
                     out_data  <= '0;
                     out_row   <= '0;
                     out_col   <= '0;
                     out_last  <= 1'b0;
                  end else begin
                     out_data  <= shape(rd_data);
                     out_row   <= idx[IW-1:LG];
                     out_col   <= idx[LG-1:0];
                     out_last  <= (idx == LAST_IDX);
                     idx       <= idx + IW'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sa_drain_collector.sv
// Self-checking bench for sa_drain_collector (N=4, ACC_W=20, FIRST_LAT=2).
// The reference is simply the tile as a row-major array; expected output word
// w is tile[w] (clamped when DRAIN_RELU_EN is defined).
module tb_sa_drain_collector;

   localparam int N  = 4;
   localparam int AW = 20;
   localparam int FL = 2;
   localparam int LG = $clog2(N);

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              sync_reset = 1'b0;
   logic              drain_start = 1'b0;
   logic              out_ready = 1'b0;
   logic [N*AW-1:0]   col_in = '0;
   logic              out_valid, out_last, busy, overrun;
   logic [AW-1:0]     out_data;
   logic [LG-1:0]     out_row, out_col;

   int                n_chk = 0;
   int                n_pass = 0;
   logic [AW-1:0]     tile [N*N];
   bit                ovr_pend = 1'b0;

   sa_drain_collector #(.N(N), .ACC_W(AW), .FIRST_LAT(FL)) dut (
      .clk(clk), .rst(rst), .sync_reset(sync_reset), .drain_start(drain_start),
      .col_in(col_in), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_row(out_row), .out_col(out_col),
      .out_last(out_last), .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [AW-1:0] ref_word(input int w);
      logic [AW-1:0] v;
      v = tile[w];
`ifdef DRAIN_RELU_EN
      if ($signed(v) < 0) v = '0;
`endif
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_ovr();
      chk("overrun", overrun, ovr_pend);
      ovr_pend = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_valid"}, out_valid, 0);
      chk({tag, "_busy"},  busy, 0);
      chk({tag, "_data"},  out_data, 0);
      chk({tag, "_row"},   out_row, 0);
      chk({tag, "_col"},   out_col, 0);
      chk({tag, "_last"},  out_last, 0);
      chk({tag, "_ovr"},   overrun, 0);
   endtask

   // column c carries PE row N-1-k at cycle offset FL+c+k from the start pulse
   task automatic drive_cols(input int off);
      for (int c = 0; c < N; c++) begin
         int k;
         k = off - FL - c;
         if (k >= 0 && k < N) col_in[c*AW +: AW] = tile[(N-1-k)*N + c];
         else                 col_in[c*AW +: AW] = AW'($urandom);
      end
   endtask

   task automatic fill_basic();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) tile[r*N + c] = AW'(100 * r + c);
   endtask

   task automatic fill_random();
      for (int i = 0; i < N*N; i++) tile[i] = AW'($urandom);
   endtask

   // rmode: 0 ready high, 1 ready pattern 1,0,0,1, 2 random ready
   task automatic run_tile(input int rmode, input int ovr_cap_off, input int ovr_word,
                           input int abort_word, input int arst_off);
      int w;
      bit done, started, ovr_done;
      w = 0; done = 0; started = 0; ovr_done = 0;
      for (int off = 0; off <= FL + 2*N - 2; off++) begin
         step();
         check_ovr();
         drain_start = (off == 0) || (off == ovr_cap_off);
         if (off == ovr_cap_off) ovr_pend = 1'b1;
         drive_cols(off);
         if (off == 0) chk("busy_idle", busy, 0);
         if (off == 1) chk("busy_rise", busy, 1);
         chk("valid_cap", out_valid, 0);
         if (off == arst_off) begin
            rst = 1'b0;
            #1;
            check_all_zero("arst");
            drain_start = 1'b0;
            ovr_pend = 1'b0;
            step();
            rst = 1'b1;
            return;
         end
      end
      for (int cyc = 0; cyc < 200 && !done; cyc++) begin
         step();
         check_ovr();
         drain_start = 1'b0;
         col_in = {N{AW'($urandom)}};
         case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         if (w == N*N) begin
            chk("valid_drop", out_valid, 0);
            chk("busy_drop", busy, 0);
            done = 1;
         end else if (!out_valid) begin
            if (started) chk("valid_held", out_valid, 1);
         end else begin
            started = 1;
            chk("data", out_data, ref_word(w));
            chk("row",  out_row, w / N);
            chk("col",  out_col, w % N);
            chk("last", out_last, (w == N*N-1));
            if (w == abort_word) begin
               sync_reset = 1'b1;
               step();
               sync_reset = 1'b0;
               out_ready = 1'b0;
               chk("abort_valid", out_valid, 0);
               chk("abort_busy", busy, 0);
               chk("abort_data", out_data, 0);
               ovr_pend = 1'b0;
               return;
            end
            if (w == ovr_word && !ovr_done) begin
               drain_start = 1'b1;
               ovr_pend = 1'b1;
               ovr_done = 1;
            end
            if (out_ready) w++;
         end
      end
      if (!done) chk("stream_timeout", w, N*N);
      out_ready = 1'b0;
      drain_start = 1'b0;
   endtask

   initial begin
      step();
      check_all_zero("reset");
      rst = 1'b1;
      step();
      chk("idle_valid", out_valid, 0);

      // basic tile, full throughput
      fill_basic();
      run_tile(0, -1, -1, -1, -1);
      // same tile under backpressure
      run_tile(1, -1, -1, -1, -1);

      // signed extremes in column 2 (rows 3..0 = words k=0..3)
      fill_random();
      tile[3*N + 2] = 20'hFFFFF;
      tile[2*N + 2] = 20'h80000;
      tile[1*N + 2] = 20'h7FFFF;
      tile[0*N + 2] = 20'h00000;
      run_tile(2, -1, -1, -1, -1);

      // overrun during capture and stream; then on the final handshake
      fill_basic();
      run_tile(0, 4, 9, -1, -1);
      run_tile(1, -1, N*N-1, -1, -1);

      // sync abort at word 5, then a clean tile
      run_tile(0, -1, -1, 5, -1);
      run_tile(0, -1, -1, -1, -1);

      // async reset mid-capture, then a clean random tile
      fill_random();
      run_tile(0, -1, -1, -1, 4);
      run_tile(2, -1, -1, -1, -1);

      for (int t = 0; t < 4; t++) begin
         fill_random();
         run_tile(t % 3, -1, -1, -1, -1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
